// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        RESP = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the LSU: merges store data into a full word and
// selects/extends load data from a full word (little-endian lanes).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] merged,
    output logic [31:0] load_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{addr_lo, 3'b000} +: 8];
    assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        merged = word;
        case (funct3[1:0])
            2'b00:   merged[{addr_lo, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit in front of a full-word data memory without byte enables.
// Sub-word stores are read-modify-write; loads are extended before returning.
//
//   state | meaning
//   IDLE  | ready for a request
//   RD    | read target word into rd_q
//   WR    | write merged (or full) word, mem_we high
//   RESP  | successful response strobe
//   ERR   | error response strobe, no memory write
module lsu_ctrl #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400,
    parameter int          DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              resp_fault,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import lsu_pkg::*;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rd_q;
    logic [2:0]  f3_q;
    logic        we_q, mis_q, fault_q;
    logic        accept, f3_legal, misal_raw, range_bad, req_mis, req_fault;
    logic [31:0] merged, load_data;

    assign accept = req_valid && (state == IDLE);

    // Priority: illegal funct3 > misaligned > out-of-range.
    always_comb begin
        if (req_we)
            f3_legal = req_funct3 inside {F3_B, F3_H, F3_W};
        else
            f3_legal = req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        misal_raw = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        range_bad = req_addr >= ADDR_LIMIT;
        req_mis   = f3_legal && misal_raw;
        req_fault = !f3_legal || (!misal_raw && range_bad);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            f3_q    <= '0;
            we_q    <= 1'b0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                f3_q    <= req_funct3;
                we_q    <= req_we;
                mis_q   <= req_mis;
                fault_q <= req_fault;
            end
            if (state == RD)
                rd_q <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) begin
                if (req_mis || req_fault)           state_nxt = ERR;
                else if (req_we && req_funct3 == F3_W) state_nxt = WR;
                else                                state_nxt = RD;
            end
            RD:       state_nxt = we_q ? WR : RESP;
            WR:       state_nxt = RESP;
            RESP:     state_nxt = IDLE;
            ERR:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    lsu_align u_align (
        .word      (rd_q),
        .addr_lo   (addr_q[1:0]),
        .funct3    (f3_q),
        .wdata     (wdata_q),
        .merged    (merged),
        .load_data (load_data)
    );

    always_comb begin
        req_ready       = (state == IDLE);
        resp_valid      = (state == RESP) || (state == ERR);
        resp_misaligned = (state == ERR) && mis_q;
        resp_fault      = (state == ERR) && fault_q;
        resp_rdata      = ((state == RESP) && !we_q) ? load_data : '0;
        mem_we          = (state == WR);
        mem_wdata       = (state == WR) ? merged : '0;
        mem_addr        = {addr_q[31:2], 2'b00};
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, corner sequences, and random
// requests checked against a byte-array reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_misaligned, resp_fault;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic        bk_we = 1'b0;
    logic [7:0]  bk_idx = '0;
    logic [31:0] bk_val = '0;
    int          we_pulses = 0;

    logic [7:0]  ref_bytes [0:1023];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // data_memory stand-in: combinational read, clocked full-word write
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            we_pulses <= we_pulses + 1;
        end else if (bk_we) begin
            mem[bk_idx] <= bk_val;
        end
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_fault;
        int          exp_lat;
        logic        chk_word;
        logic [31:0] exp_word;
    } vec_t;

    function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] er, logic em, logic ef, int el,
                                logic cw, logic [31:0] ew);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.exp_rdata = er;
        v.exp_mis = em; v.exp_fault = ef; v.exp_lat = el; v.chk_word = cw; v.exp_word = ew;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        @(negedge clk);
        bk_we = 1'b1; bk_idx = 8'(idx); bk_val = v;
        @(posedge clk);
        #1 bk_we = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rdata,
                          output logic mis, output logic flt, output int lat,
                          output int pulses, output logic rdy_at_resp);
        int p0;
        rdata = '0; mis = 1'b0; flt = 1'b0; lat = 0; rdy_at_resp = 1'b1;
        @(negedge clk);
        check("ready_idle", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        p0 = we_pulses;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k > 1) @(negedge clk);
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; mis = resp_misaligned;
                flt = resp_fault; rdy_at_resp = req_ready;
                break;
            end
        end
        pulses = we_pulses - p0;
        if (lat == 0) begin
            failures++;
            checks++;
            $display("FAIL resp_timeout got=none expected=resp within 8 cycles");
        end
    endtask

    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd,
                         output logic mis, output logic flt, output int lat, output int pulses);
        int          size;
        logic        legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        mis   = legal && ((a % size) != 0);
        flt   = !legal || (!mis && a >= 32'h400);
        rd = '0; pulses = 0; lat = 1;
        if (!(mis || flt)) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_bytes[a + i] = wd[8*i +: 8];
                pulses = 1;
                lat = (size == 4) ? 2 : 3;
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[a + i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rd = v;
                lat = 2;
            end
        end
    endtask

    vec_t        vecs [18];
    logic [31:0] g_rd, e_rd, w;
    logic        g_mis, g_flt, g_rdy, e_mis, e_flt, saw_resp;
    int          g_lat, g_pul, e_lat, e_pul, p0;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",     {31'h0, req_ready},       32'd1);
        check("rst_resp_val",  {31'h0, resp_valid},      32'd0);
        check("rst_rdata",     resp_rdata,               32'd0);
        check("rst_mis",       {31'h0, resp_misaligned}, 32'd0);
        check("rst_fault",     {31'h0, resp_fault},      32'd0);
        check("rst_mem_we",    {31'h0, mem_we},          32'd0);
        check("rst_mem_addr",  mem_addr,                 32'd0);
        check("rst_mem_wdata", mem_wdata,                32'd0);
        poke(4, 32'h8899_AABB);
        poke(8, 32'h1122_3344);
        poke(9, 32'hA5A5_A5A5);
        @(negedge clk) rst = 1'b0;

        //          we    f3      addr          wdata         rdata          mis   flt  lat chk  word
        vecs[0]  = mk(1'b0, 3'b010, 32'h10,  32'h0,         32'h8899_AABB, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 3'b000, 32'h11,  32'h0,         32'hFFFF_FFAA, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 3'b100, 32'h11,  32'h0,         32'h0000_00AA, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[3]  = mk(1'b0, 3'b001, 32'h12,  32'h0,         32'hFFFF_8899, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[4]  = mk(1'b0, 3'b101, 32'h12,  32'h0,         32'h0000_8899, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 3'b000, 32'h13,  32'h0,         32'hFFFF_FF88, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[6]  = mk(1'b1, 3'b000, 32'h22,  32'hDEAD_BE5A, 32'h0,         1'b0, 1'b0, 3, 1'b1, 32'h115A_3344);
        vecs[7]  = mk(1'b1, 3'b001, 32'h20,  32'h0000_CAFE, 32'h0,         1'b0, 1'b0, 3, 1'b1, 32'h115A_CAFE);
        vecs[8]  = mk(1'b0, 3'b010, 32'h20,  32'h0,         32'h115A_CAFE, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 3'b010, 32'h06,  32'h0,         32'h0,         1'b1, 1'b0, 1, 1'b0, 32'h0);
        vecs[10] = mk(1'b1, 3'b010, 32'h400, 32'h1,         32'h0,         1'b0, 1'b1, 1, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 3'b011, 32'h0,   32'h0,         32'h0,         1'b0, 1'b1, 1, 1'b0, 32'h0);
        vecs[12] = mk(1'b1, 3'b010, 32'h3FC, 32'h1234_5678, 32'h0,         1'b0, 1'b0, 2, 1'b1, 32'h1234_5678);
        vecs[13] = mk(1'b0, 3'b010, 32'h3FC, 32'h0,         32'h1234_5678, 1'b0, 1'b0, 2, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 3'b001, 32'h13,  32'h0,         32'h0,         1'b1, 1'b0, 1, 1'b0, 32'h0);
        vecs[15] = mk(1'b1, 3'b101, 32'h401, 32'h0,         32'h0,         1'b0, 1'b1, 1, 1'b0, 32'h0);
        vecs[16] = mk(1'b0, 3'b010, 32'h402, 32'h0,         32'h0,         1'b1, 1'b0, 1, 1'b0, 32'h0);
        vecs[17] = mk(1'b1, 3'b100, 32'h10,  32'hFFFF_FFFF, 32'h0,         1'b0, 1'b1, 1, 1'b0, 32'h0);

        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                   g_rd, g_mis, g_flt, g_lat, g_pul, g_rdy);
            check($sformatf("v%0d_rdata", i), g_rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_mis", i), {31'h0, g_mis}, {31'h0, vecs[i].exp_mis});
            check($sformatf("v%0d_fault", i), {31'h0, g_flt}, {31'h0, vecs[i].exp_fault});
            check($sformatf("v%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_we_pulses", i), 32'(g_pul),
                  (vecs[i].we && !vecs[i].exp_mis && !vecs[i].exp_fault) ? 32'd1 : 32'd0);
            check($sformatf("v%0d_ready_busy", i), {31'h0, g_rdy}, 32'd0);
            if (vecs[i].chk_word)
                check($sformatf("v%0d_mem_word", i), mem[vecs[i].addr[9:2]], vecs[i].exp_word);
        end

        // Reset during the RD cycle of an SB aborts cleanly
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h25; req_wdata = 32'h77;
        p0 = we_pulses;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_ready", {31'h0, req_ready}, 32'd1);
        check("abort_mem_we", {31'h0, mem_we}, 32'd0);
        check("abort_resp", {31'h0, resp_valid}, 32'd0);
        @(negedge clk) rst = 1'b0;
        saw_resp = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) saw_resp = 1'b1;
        end
        check("abort_no_resp", {31'h0, saw_resp}, 32'd0);
        check("abort_no_we", 32'(we_pulses - p0), 32'd0);
        check("abort_word", mem[9], 32'hA5A5_A5A5);

        // Back-to-back: LW issued in the first IDLE cycle after the SW response
        do_req(1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, g_rd, g_mis, g_flt, g_lat, g_pul, g_rdy);
        check("b2b_sw_lat", 32'(g_lat), 32'd2);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, g_rd, g_mis, g_flt, g_lat, g_pul, g_rdy);
        check("b2b_lw_data", g_rd, 32'hCAFE_F00D);
        check("b2b_lw_lat", 32'(g_lat), 32'd2);

        // Random requests against the byte-level reference
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            poke(i, w);
            for (int b = 0; b < 4; b++) ref_bytes[4*i + b] = w[8*b +: 8];
        end
        for (int n = 0; n < 250; n++) begin
            r_we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) r_f3 = 3'($urandom_range(0, 7));
            else if (r_we)                  r_f3 = 3'($urandom_range(0, 2));
            else begin
                r_f3 = 3'($urandom_range(0, 4));
                if (r_f3 == 3'd3) r_f3 = 3'd5;
            end
            r_a = 32'($urandom_range(0, 32'h40F));
            if ($urandom_range(0, 1) == 1) r_a[1:0] = 2'b00;
            r_wd = $urandom;
            model(r_we, r_f3, r_a, r_wd, e_rd, e_mis, e_flt, e_lat, e_pul);
            do_req(r_we, r_f3, r_a, r_wd, g_rd, g_mis, g_flt, g_lat, g_pul, g_rdy);
            check($sformatf("rnd%0d_rdata", n), g_rd, e_rd);
            check($sformatf("rnd%0d_flags", n), {30'h0, g_mis, g_flt}, {30'h0, e_mis, e_flt});
            check($sformatf("rnd%0d_latency", n), 32'(g_lat), 32'(e_lat));
            check($sformatf("rnd%0d_we_pulses", n), 32'(g_pul), 32'(e_pul));
            if (r_we && !e_mis && !e_flt) begin
                w = {ref_bytes[{r_a[9:2], 2'd3}], ref_bytes[{r_a[9:2], 2'd2}],
                     ref_bytes[{r_a[9:2], 2'd1}], ref_bytes[{r_a[9:2], 2'd0}]};
                check($sformatf("rnd%0d_mem_word", n), mem[r_a[9:2]], w);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
